// File: rtl/sym_fir_serial.sv
// sym_fir_serial: symmetric (linear-phase) FIR filter built around one shared
// pre-add/multiply/accumulate unit. Each accepted sample costs TAPS/2 MAC
// cycles, one folded tap pair per clock, followed by one output cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear of delay line, accumulator, in-flight work
//   din/din_valid   input sample and its valid strobe
//   din_ready       high only in IDLE; a sample is taken when valid && ready
//   dout            rounded, shifted, saturated result (held between results)
//   dout_valid      one-cycle pulse marking a new dout
//   dout_sat        qualifies dout_valid: the result was clamped
//   coef_we/addr/data  coefficient write port (TAPS/2 folded coefficients)
//   coef_ready      high only in IDLE; writes outside IDLE are dropped
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | accumulating tap pair k, k = 0 .. TAPS/2-1
// OUT   | rounding, shifting and saturating acc into dout

module sym_fir_serial #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int TAPS      = 16,
   parameter int OUT_SHIFT = 15,
   parameter int ROUND     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic [DATA_W-1:0]             din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic [DATA_W-1:0]             dout,
   output logic                          dout_valid,
   output logic                          dout_sat,
   input  logic                          coef_we,
   input  logic [$clog2(TAPS/2)-1:0]     coef_addr,
   input  logic [COEF_W-1:0]             coef_data,
   output logic                          coef_ready
);

   localparam int HALF  = TAPS / 2;
   localparam int AW    = $clog2(HALF);
   localparam int TW    = $clog2(TAPS);
   localparam int PW    = DATA_W + 1 + COEF_W;
   localparam int ACC_W = PW + AW;

   localparam logic signed [ACC_W:0] RND =
      (ROUND != 0) ? ((ACC_W+1)'(1) <<< (OUT_SHIFT - 1)) : '0;
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
   localparam logic [AW-1:0]         K_LAST  = AW'(HALF - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                     state;
   logic signed [DATA_W-1:0]   dl   [TAPS];
   logic signed [COEF_W-1:0]   coef [HALF];
   logic signed [ACC_W-1:0]    acc;
   logic [AW-1:0]              k;

   logic [TW-1:0]              k_lo;
   logic [TW-1:0]              k_hi;
   logic signed [DATA_W:0]     pre;
   logic signed [PW-1:0]       prod;
   logic signed [ACC_W:0]      acc_rnd;
   logic signed [ACC_W:0]      acc_sh;
   logic                       ovf_hi;
   logic                       ovf_lo;
   logic [DATA_W-1:0]          sat_val;

   assign din_ready  = (state == IDLE);
   assign coef_ready = (state == IDLE);

   // Folded tap pair: dl[k] and its mirror dl[TAPS-1-k] share coef[k].
   assign k_lo = TW'(k);
   assign k_hi = TW'(TAPS - 1) - k_lo;
   assign pre  = (DATA_W+1)'(dl[k_lo]) + (DATA_W+1)'(dl[k_hi]);
   assign prod = PW'(pre) * PW'(coef[k]);

   // One extra bit keeps the rounding add from wrapping at the acc extremes.
   assign acc_rnd = (ACC_W+1)'(acc) + RND;
   assign acc_sh  = acc_rnd >>> OUT_SHIFT;
   assign ovf_hi  = (acc_sh > SAT_MAX);
   assign ovf_lo  = (acc_sh < SAT_MIN);
   assign sat_val = ovf_hi ? SAT_MAX[DATA_W-1:0] :
                    ovf_lo ? SAT_MIN[DATA_W-1:0] : acc_sh[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         k          <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_sat   <= 1'b0;
         for (int i = 0; i < TAPS; i++) dl[i] <= '0;
         for (int i = 0; i < HALF; i++) coef[i] <= '0;
      end else begin
         dout_valid <= 1'b0;
         if (clr) begin
            state <= IDLE;
            acc   <= '0;
            k     <= '0;
            for (int i = 0; i < TAPS; i++) dl[i] <= '0;
         end else begin
            case (state)
               IDLE: begin
                  // A write on the accept edge lands before the first MAC cycle.
                  if (coef_we) coef[coef_addr] <= coef_data;
                  if (din_valid) begin
                     for (int i = TAPS - 1; i > 0; i--) dl[i] <= dl[i-1];
                     dl[0] <= din;
                     acc   <= '0;
                     k     <= '0;
                     state <= MAC;
                  end
               end
               MAC: begin
                  acc <= acc + ACC_W'(prod);
                  k   <= k + 1'b1;
                  if (k == K_LAST) state <= OUT;
               end
               OUT: begin
                  dout       <= sat_val;
                  dout_sat   <= ovf_hi | ovf_lo;
                  dout_valid <= 1'b1;
                  state      <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sym_fir_serial.sv
// tb_sym_fir_serial: directed bench for sym_fir_serial. Instance u0 uses the
// defaults (16 taps, rounding); u1 is an 8-tap truncating build. Both share
// data/address/clear/reset lines and have their own strobes.

module tb_sym_fir_serial;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        clr;
   logic [15:0] din;
   logic [2:0]  coef_addr;
   logic [15:0] coef_data;
   logic [1:0]  din_valid;
   logic [1:0]  coef_we;
   logic [1:0]  din_ready;
   logic [1:0]  dout_valid;
   logic [1:0]  dout_sat;
   logic [1:0]  coef_ready;
   logic [15:0] dout0;
   logic [15:0] dout1;

   sym_fir_serial u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .din(din), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
      .dout(dout0), .dout_valid(dout_valid[0]), .dout_sat(dout_sat[0]),
      .coef_we(coef_we[0]), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_ready(coef_ready[0])
   );

   sym_fir_serial #(.TAPS(8), .ROUND(0)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .din(din), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
      .dout(dout1), .dout_valid(dout_valid[1]), .dout_sat(dout_sat[1]),
      .coef_we(coef_we[1]), .coef_addr(coef_addr[1:0]), .coef_data(coef_data),
      .coef_ready(coef_ready[1])
   );

   int     n_cmp = 0;
   int     n_err = 0;

   int     dl_m [2][16];
   int     cf_m [2][8];
   longint exp_d;
   longint exp_s;

   typedef struct {
      int s;
      int c;
      int x;
      int ed;
      int es;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint got_dout(input int s);
      logic signed [15:0] v;
      v = (s == 0) ? dout0 : dout1;
      return longint'(v);
   endfunction

   function automatic void model_clear_dl();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++) dl_m[s][i] = 0;
   endfunction

   // Reference: full symmetric convolution in wide integers, then round/shift/clamp.
   function automatic void model_accept(input int s, input int x);
      int     t;
      longint acc;
      t   = (s == 0) ? 16 : 8;
      acc = 0;
      for (int i = t - 1; i > 0; i--) dl_m[s][i] = dl_m[s][i-1];
      dl_m[s][0] = x;
      for (int j = 0; j < t / 2; j++)
         acc += (longint'(dl_m[s][j]) + longint'(dl_m[s][t-1-j])) * longint'(cf_m[s][j]);
      if (s == 0) acc += 64'sd16384;
      acc   = acc >>> 15;
      exp_s = 0;
      if (acc > 32767) begin
         acc   = 32767;
         exp_s = 1;
      end else if (acc < -32768) begin
         acc   = -32768;
         exp_s = 1;
      end
      exp_d = acc;
   endfunction

   task automatic write_coef(input int s, input int a, input int v);
      coef_we[s] = 1'b1;
      coef_addr  = 3'(a);
      coef_data  = 16'(v);
      @(posedge clk);
      cf_m[s][a] = v;
      #1 coef_we[s] = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      model_clear_dl();
   endtask

   task automatic wait_dv(input int s, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!dout_valid[s] && lat < 40);
      if (!dout_valid[s]) chk("dv_timeout", 0, 1);
   endtask

   task automatic send(input int s, input int x, input string name);
      int lat;
      chk({name, "_rdy"}, din_ready[s], 1);
      din          = 16'(x);
      din_valid[s] = 1'b1;
      @(posedge clk);
      model_accept(s, x);
      #1 din_valid[s] = 1'b0;
      wait_dv(s, lat);
      chk({name, "_lat"}, lat, (s == 0) ? 9 : 5);
      chk({name, "_dout"}, got_dout(s), exp_d);
      chk({name, "_sat"}, dout_sat[s], exp_s);
   endtask

   task automatic impulse_stream();
      int     t;
      int     na;
      int     nr;
      int     acc_t [16];
      int     res_t [16];
      longint res_d [16];
      longint ex [16];
      t  = 0;
      na = 0;
      nr = 0;
      while (nr < 16 && t < 400) begin
         @(posedge clk);
         #1 t++;
         if (dout_valid[0]) begin
            if (nr == 0) chk("imp_latency", t - acc_t[0], 9);
            else         chk("imp_spacing", t - res_t[nr-1], 10);
            chk("imp_dout", got_dout(0), ex[nr]);
            res_t[nr] = t;
            res_d[nr] = got_dout(0);
            nr++;
         end
         if (din_ready[0] && na < 16) begin
            din          = (na == 0) ? 16'd16384 : 16'd0;
            din_valid[0] = 1'b1;
            acc_t[na]    = t + 1;
            model_accept(0, (na == 0) ? 16384 : 0);
            ex[na] = exp_d;
            na++;
         end else if (na >= 16) begin
            din_valid[0] = 1'b0;
         end
      end
      din_valid[0] = 1'b0;
      if (nr < 16) chk("imp_timeout", nr, 16);
      else begin
         chk("imp_res0", res_d[0], 8192);
         chk("imp_res7", res_d[7], 0);
         chk("imp_res15", res_d[15], 8192);
      end
   endtask

   initial begin
      int lat;
      int seen;
      logic signed [15:0] r;

      tbl[0] = '{0,      1,  16384,      1, 0};
      tbl[1] = '{1,      1,  16384,      0, 0};
      tbl[2] = '{0,      1, -16384,      0, 0};
      tbl[3] = '{1,      1, -16384,     -1, 0};
      tbl[4] = '{0,  16384,  16384,   8192, 0};
      tbl[5] = '{0, -32768, -32768,  32767, 1};
      tbl[6] = '{0,  32767, -32768, -32767, 0};
      tbl[7] = '{1, -32768, -32768,  32767, 1};

      rst_n = 1'b0;
      clr = 1'b0;
      din = '0;
      din_valid = '0;
      coef_we = '0;
      coef_addr = '0;
      coef_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_dout", got_dout(0), 0);
      chk("rst_dout_valid", dout_valid[0], 0);
      chk("rst_dout_sat", dout_sat[0], 0);
      chk("rst_din_ready", din_ready[0], 1);
      chk("rst_coef_ready", coef_ready[0], 1);
      chk("rst_dout_u1", got_dout(1), 0);

      // Single-sample rounding / truncation / saturation vectors.
      for (int i = 0; i < 8; i++) begin
         write_coef(tbl[i].s, 0, tbl[i].c);
         do_clr();
         send(tbl[i].s, tbl[i].x, "tbl");
         chk("tbl_hand_dout", got_dout(tbl[i].s), tbl[i].ed);
         chk("tbl_hand_sat", dout_sat[tbl[i].s], tbl[i].es);
      end

      // Impulse with din_valid held high.
      write_coef(0, 0, 16384);
      do_clr();
      impulse_stream();

      // Saturation, both polarities.
      for (int j = 0; j < 8; j++) write_coef(0, j, 32767);
      do_clr();
      for (int i = 0; i < 16; i++) send(0, 32767, "satp");
      chk("satp_final", got_dout(0), 32767);
      chk("satp_flag", dout_sat[0], 1);
      do_clr();
      for (int i = 0; i < 16; i++) send(0, -32768, "satn");
      chk("satn_final", got_dout(0), -32768);
      chk("satn_flag", dout_sat[0], 1);

      // Coefficient write while busy is dropped.
      for (int j = 0; j < 8; j++) write_coef(0, j, (j == 0) ? 16384 : 0);
      do_clr();
      din = 16'd16384;
      din_valid[0] = 1'b1;
      @(posedge clk);
      model_accept(0, 16384);
      #1 din_valid[0] = 1'b0;
      coef_we[0] = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'd1000;
      chk("busy_coef_ready", coef_ready[0], 0);
      @(posedge clk);
      #1 coef_we[0] = 1'b0;
      wait_dv(0, lat);
      chk("busy_dout", got_dout(0), exp_d);
      chk("busy_hand", got_dout(0), 8192);

      write_coef(0, 0, 1000);
      do_clr();
      send(0, 16384, "idle_wr");
      chk("idle_wr_hand", got_dout(0), 500);

      // Write on the accept edge is used by that sample.
      din = 16'd16384;
      din_valid[0] = 1'b1;
      coef_we[0] = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'd2000;
      @(posedge clk);
      cf_m[0][0] = 2000;
      model_accept(0, 16384);
      #1 din_valid[0] = 1'b0;
      coef_we[0] = 1'b0;
      wait_dv(0, lat);
      chk("same_edge_lat", lat, 9);
      chk("same_edge_dout", got_dout(0), exp_d);
      chk("same_edge_hand", got_dout(0), 1000);

      // clr in the 4th MAC cycle aborts the sample and wipes history.
      for (int j = 0; j < 8; j++) write_coef(0, j, 1000 * (j + 1));
      send(0, 12345, "pre_clr");
      din = 16'd12345;
      din_valid[0] = 1'b1;
      @(posedge clk);
      #1 din_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      model_clear_dl();
      chk("clr_din_ready", din_ready[0], 1);
      chk("clr_dout_valid", dout_valid[0], 0);
      seen = 0;
      repeat (15) begin
         @(posedge clk);
         #1 if (dout_valid[0]) seen++;
      end
      chk("clr_no_result", seen, 0);
      send(0, 16384, "post_clr");
      chk("post_clr_hand", got_dout(0), 500);

      // Reset pulse during MAC.
      din = 16'd16384;
      din_valid[0] = 1'b1;
      @(posedge clk);
      #1 din_valid[0] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_dout", got_dout(0), 0);
      chk("rst_mid_dout_valid", dout_valid[0], 0);
      chk("rst_mid_din_ready", din_ready[0], 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear_dl();
      for (int s = 0; s < 2; s++)
         for (int j = 0; j < 8; j++) cf_m[s][j] = 0;
      send(0, 16384, "post_rst");
      chk("post_rst_hand", got_dout(0), 0);

      // Random coefficients and samples against the reference, both builds.
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < ((s == 0) ? 8 : 4); j++) begin
            r = 16'($urandom);
            write_coef(s, j, int'(r) >>> 2);
         end
         do_clr();
         for (int i = 0; i < 64; i++) begin
            r = 16'($urandom);
            send(s, int'(r), "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
